// File: rtl/layer_mixer.sv
// Priority compositor: NUM_LAYERS colour streams + bg fill -> registered VGA colour, with per-layer enable/blink.
// Latency: fixed 2 cycles from layer_rgb/video_on to vga_rgb (stage 1 hit vector, stage 2 priority select).
// Backpressure: none, streams at pixel rate. Optional LAYER_MIXER_HIT_REPORT_EN adds hit_valid/hit_layer.
module layer_mixer #(
    parameter int                 NUM_LAYERS  = 3,
    parameter int                 COLOR_W     = 5,
    parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
    parameter int                 BLINK_DIV   = 30
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          video_on,
    input  logic                          frame_tick,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS-1:0]         blink_mask,
    input  logic [COLOR_W-1:0]            bg_rgb,
    output logic [COLOR_W-1:0]            vga_rgb,
`ifdef LAYER_MIXER_HIT_REPORT_EN
    output logic                          hit_valid,
    output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] hit_layer,
`endif
    output logic                          blink_phase
);

    localparam int HL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic [7:0]                    blink_cnt;
    logic [NUM_LAYERS-1:0]         hit_c;
    logic [NUM_LAYERS-1:0]         hit_d;
    logic [NUM_LAYERS*COLOR_W-1:0] rgb_d;
    logic                          video_on_d;
    logic                          any_hit;
    logic [COLOR_W-1:0]            sel_rgb;
    logic [COLOR_W-1:0]            vga_nxt;

    // Phase only moves on frame_tick so a line is never split between phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == 8'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        hit_c = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            hit_c[i] = layer_en[i]
                     & (layer_rgb[i*COLOR_W +: COLOR_W] != TRANSPARENT)
                     & ~(blink_mask[i] & blink_phase);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_d      <= '0;
            rgb_d      <= '0;
            video_on_d <= 1'b0;
        end else begin
            hit_d      <= hit_c;
            rgb_d      <= layer_rgb;
            video_on_d <= video_on;
        end
    end

    // Walk from the lowest priority up so the lowest set index wins.
    always_comb begin
        any_hit = 1'b0;
        sel_rgb = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit_d[i]) begin
                any_hit = 1'b1;
                sel_rgb = rgb_d[i*COLOR_W +: COLOR_W];
            end
        end
        vga_nxt = video_on_d ? (any_hit ? sel_rgb : bg_rgb) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vga_rgb <= '0;
        else        vga_rgb <= vga_nxt;
    end

`ifdef LAYER_MIXER_HIT_REPORT_EN
    logic [HL_W-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit_d[i]) win_idx = HL_W'(i);
        end
    end

    // Reported hit is gated by video_on so it always describes what vga_rgb shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_valid <= 1'b0;
            hit_layer <= '0;
        end else begin
            hit_valid <= video_on_d & any_hit;
            hit_layer <= (video_on_d & any_hit) ? win_idx : '0;
        end
    end
`endif

endmodule
